parity_frame_tx: RTL and testbench

- Serial frame transmitter directly downstream of the 8-bit parity generator.
- Consumes one 9-bit parity-extended word: bit 8 is the parity bit, bits 7:0 are data. The word is either the Even or Odd output, chosen at integration.
- Shifts the word out on one line as: start bit, 8 data bits LSB first, parity bit, stop bit(s).
- Uses a valid/ready handshake on the input side and a per-bit clock divider.

---
 rtl/parity_frame_tx.sv | 120 ++++++++++++
 tb/tb_parity_frame_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/parity_frame_tx.sv
// parity_frame_tx
//   Serial transmitter for one 9-bit parity-extended word per frame.
//   Line format: start(0), data[0..7] LSB first, parity (din[8]), STOP_BITS x stop(1).
//   Every bit is held for CLKS_PER_BIT clock cycles. The parity bit goes out as supplied.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   din        [8] parity bit, [7:0] data; sampled only when a word is accepted
//   din_valid  din holds a word to send
//   din_ready  high exactly while idle; a word is taken when din_valid is also high
//   tx         serial line, idles high
//   busy       frame in progress
//   done       one-cycle pulse after the last stop bit
module parity_frame_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      st_idle, st_start, st_data, st_parity, st_stop
   } state_t;

   localparam logic [15:0] DIV_TC = 16'(CLKS_PER_BIT - 1);
   localparam logic        SB_TC  = 1'(STOP_BITS - 1);

   state_t      state, state_nxt;
   logic [15:0] div, div_nxt;
   logic [2:0]  idx, idx_nxt;
   logic        sb, sb_nxt;
   logic [8:0]  shreg;
   logic        accept, tc;
   logic        tx_nxt, busy_nxt, ready_nxt, done_nxt;

   assign accept = (state == st_idle) && din_valid;
   assign tc     = (div == DIV_TC);

   // State register. Outputs are registered from their next values so that
   // tx already shows the start bit in the cycle following the accept edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= st_idle;
         div       <= '0;
         idx       <= '0;
         sb        <= 1'b0;
         shreg     <= '0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         din_ready <= 1'b1;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         div       <= div_nxt;
         idx       <= idx_nxt;
         sb        <= sb_nxt;
         if (accept) shreg <= din;
         tx        <= tx_nxt;
         busy      <= busy_nxt;
         din_ready <= ready_nxt;
         done      <= done_nxt;
      end
   end

   // Next-state logic. The divider restarts whenever the bit on the line changes.
   always_comb begin
      state_nxt = state;
      div_nxt   = tc ? '0 : div + 16'd1;
      idx_nxt   = idx;
      sb_nxt    = sb;
      unique case (state)
         st_idle: begin
            div_nxt = '0;
            idx_nxt = '0;
            sb_nxt  = 1'b0;
            if (accept) state_nxt = st_start;
         end
         st_start: if (tc) begin
            state_nxt = st_data;
            idx_nxt   = '0;
         end
         st_data: if (tc) begin
            if (idx == 3'd7) state_nxt = st_parity;
            else             idx_nxt   = idx + 3'd1;
         end
         st_parity: if (tc) begin
            state_nxt = st_stop;
            sb_nxt    = 1'b0;
         end
         st_stop: if (tc) begin
            if (sb == SB_TC) state_nxt = st_idle;
            else             sb_nxt    = 1'b1;
         end
         default: state_nxt = st_idle;
      endcase
   end

   // Output logic: values the registered outputs take after this edge.
   always_comb begin
      tx_nxt    = 1'b1;
      busy_nxt  = (state_nxt != st_idle);
      ready_nxt = (state_nxt == st_idle);
      done_nxt  = (state == st_stop) && (state_nxt == st_idle);
      unique case (state_nxt)
         st_start:  tx_nxt = 1'b0;
         st_data:   tx_nxt = shreg[idx_nxt];
         st_parity: tx_nxt = shreg[8];
         default:   tx_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_parity_frame_tx.sv
module tb_parity_frame_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [8:0] din = '0;
   logic       valid = 1'b0;
   logic       sel = 1'b0;   // 0: CLKS_PER_BIT=4/STOP_BITS=1, 1: CLKS_PER_BIT=1/STOP_BITS=2
   logic       ra, ta, ba, da, rb, tb, bb, db;
   logic       va, vb;
   logic       tx, busy, ready, done;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign va = valid & ~sel;
   assign vb = valid & sel;

   parity_frame_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .din(din), .din_valid(va),
      .din_ready(ra), .tx(ta), .busy(ba), .done(da));

   parity_frame_tx #(.CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .din(din), .din_valid(vb),
      .din_ready(rb), .tx(tb), .busy(bb), .done(db));

   assign tx    = sel ? tb : ta;
   assign busy  = sel ? bb : ba;
   assign ready = sel ? rb : ra;
   assign done  = sel ? db : da;

   typedef struct {
      logic       s;
      logic [8:0] w;
      logic [10:0] bits;   // bits[0] is transmitted first
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference line pattern from the frame rules.
   function automatic logic [10:0] model(input logic [8:0] w);
      logic [10:0] m;
      m[0] = 1'b0;
      for (int i = 0; i < 8; i++) m[i+1] = w[i];
      m[9]  = w[8];
      m[10] = 1'b1;
      return m;
   endfunction

   // Entered and left at a falling edge. Accepts w at the next rising edge
   // and checks every cycle of the frame plus the done cycle.
   task automatic run_frame(input logic s, input logic [8:0] w, input logic [10:0] bits,
                            input logic keep, input logic scr);
      int cpb, sb, f, idx;
      logic e;
      cpb = s ? 1 : 4;
      sb  = s ? 2 : 1;
      f   = (10 + sb) * cpb;
      sel = s; din = w; valid = 1'b1;
      #1 chk("ready_before_accept", ready, 1);
      @(posedge clk);
      for (int t = 0; t < f; t++) begin
         @(negedge clk);
         idx = t / cpb;
         e = (idx > 10) ? 1'b1 : bits[idx];
         chk("tx_bit", tx, e);
         chk("busy_in_frame", busy, 1);
         chk("ready_in_frame", ready, 0);
         chk("done_in_frame", done, 0);
         if (!keep) valid = 1'b0;
         if (scr && idx >= 1 && idx <= 8) begin
            din = 9'h000;
            valid = t[0];
         end
         if (t == f - 1) begin
            din = w;
            valid = keep;
         end
         @(posedge clk);
      end
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("busy_at_done", busy, 0);
      chk("ready_at_done", ready, 1);
      chk("tx_idle_at_done", tx, 1);
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{1'b0, 9'h1A5, 11'b11101001010};
      vecs[1] = '{1'b0, 9'h155, 11'b11010101010};
      vecs[2] = '{1'b1, 9'h000, 11'b10000000000};
      vecs[3] = '{1'b1, 9'h1FF, 11'b11111111110};

      // Asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      chk("rst_tx_a", ta, 1);     chk("rst_ready_a", ra, 1);
      chk("rst_busy_a", ba, 0);   chk("rst_done_a", da, 0);
      chk("rst_tx_b", tb, 1);     chk("rst_busy_b", bb, 0);
      repeat (2) @(negedge clk);
      chk("rst_hold_tx", ta, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_tx", ta, 1);
      chk("idle_ready", ra, 1);

      // Table vectors
      for (int i = 0; i < 4; i++) begin
         run_frame(vecs[i].s, vecs[i].w, vecs[i].bits, 1'b0, 1'b0);
         @(negedge clk);
         chk("idle_after_frame_done", done, 0);
      end

      // Back-to-back: valid held high, second accept one cycle after done edge
      run_frame(1'b0, 9'h0A5, 11'b10101001010, 1'b1, 1'b0);
      run_frame(1'b0, 9'h1FF, 11'b11111111110, 1'b0, 1'b0);
      @(negedge clk);

      // Input changes while busy are ignored
      run_frame(1'b0, 9'h1A5, 11'b11101001010, 1'b0, 1'b1);
      @(negedge clk);

      // Reset during data bit 3 of a 9'h1A5 frame
      sel = 1'b0; din = 9'h1A5; valid = 1'b1;
      @(posedge clk);
      for (int t = 0; t < 17; t++) begin
         @(negedge clk);
         valid = 1'b0;
         chk("pre_rst_tx", tx, vecs[0].bits[t/4]);
         @(posedge clk);
      end
      @(negedge clk);
      chk("pre_rst_d3", tx, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("midrst_tx", tx, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", ready, 1);
      chk("midrst_done", done, 0);
      repeat (3) begin
         @(negedge clk);
         chk("midrst_hold_done", done, 0);
         chk("midrst_hold_tx", tx, 1);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_done", done, 0);
      run_frame(1'b0, 9'h0A5, 11'b10101001010, 1'b0, 1'b0);

      // Random words against the reference model
      for (int i = 0; i < 24; i++) begin
         logic s;
         logic [8:0] w;
         int gap;
         s   = 1'($urandom_range(0, 1));
         w   = 9'($urandom_range(0, 511));
         gap = $urandom_range(1, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("rand_idle_tx", tx, 1);
            chk("rand_idle_done", done, 0);
         end
         run_frame(s, w, model(w), 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
